aes_key_expand: RTL

Sequential AES-128 round-key generator that sits directly upstream of the cipher round datapath inside `aes_core`. It accepts the 128-bit key assembled by the SPI front end and produces round keys 0 through 10 one at a time under a valid/next handshake, so the round logic never holds all eleven keys at once. One round key is expanded per handshake, and the block runs entirely on the core oscillator clock.

---
 rtl/aes_pkg.sv | 72 +++++++
 rtl/aes_key_expand_if.sv | 30 +++
 rtl/aes_subword.sv | 34 +++
 rtl/aes_key_expand.sv | 114 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES constants and helpers for the key schedule and the cipher rounds.
//   word_t          : 32-bit AES word
//   kexp_state_e    : key-expansion FSM states (ST_SUBST only when
//                     AES_KEYEXP_SYNC_SBOX_EN is defined)
//   SBOX_TABLE      : 256-entry forward S-box, entry 0 in the top byte
//   RCON[1:10]      : round constants
//   sbox()          : single-byte S-box lookup
//   rot_word()      : rotate a word left by one byte
//   next_round_key(): one AES-128 key-schedule step from a precomputed SubWord
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
`ifdef AES_KEYEXP_SYNC_SBOX_EN
        ST_SUBST,
`endif
        ST_FINISH
    } kexp_state_e;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Entry b sits at bit offset (255 - b) * 8, and {~b, 3'b000} is exactly that.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // sub_rot is SubWord(RotWord(w3)) of the previous key, supplied by the
    // caller so the S-box can be either combinational or registered.
    function automatic logic [127:0] next_round_key(input logic [127:0] k,
                                                    input word_t        sub_rot,
                                                    input logic [7:0]   rc);
        word_t w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot ^ {rc, 24'h0};
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// -----------------------------------------------------------------------------
// aes_key_expand_if
// Request / round-key handshake between the consumer and aes_key_expand.
//   start, key, next                                  : consumer -> expander
//   round_key, round_idx, key_valid, busy, done       : expander -> consumer
// modport master : consumer side (cipher round datapath / testbench)
// modport slave  : aes_key_expand
// -----------------------------------------------------------------------------
interface aes_key_expand_if;

    logic         start;
    logic [127:0] key;
    logic         next;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    modport master (
        output start, key, next,
        input  round_key, round_idx, key_valid, busy, done
    );

    modport slave (
        input  start, key, next,
        output round_key, round_idx, key_valid, busy, done
    );

endinterface

// File: rtl/aes_subword.sv
// -----------------------------------------------------------------------------
// aes_subword
// Four parallel S-box lookups on one 32-bit word (SubWord / SubBytes column).
//   clk  : in   clock, present only when AES_KEYEXP_SYNC_SBOX_EN is defined
//   din  : in   32-bit word
//   dout : out  byte-wise S-box of din; combinational by default, one cycle
//               late when AES_KEYEXP_SYNC_SBOX_EN is defined (maps to EBR)
// -----------------------------------------------------------------------------
module aes_subword
    import aes_pkg::*;
(
`ifdef AES_KEYEXP_SYNC_SBOX_EN
    input  logic  clk,
`endif
    input  word_t din,
    output word_t dout
);

    word_t sub;

    assign sub = {sbox(din[31:24]), sbox(din[23:16]),
                  sbox(din[15:8]),  sbox(din[7:0])};

`ifdef AES_KEYEXP_SYNC_SBOX_EN
    // NOTE: no reset on this register: it is pure lookup data, consumers only
    // use it a cycle after driving din, and a reset would block the EBR mapping.
    always_ff @(posedge clk) begin
        dout <= sub;
    end
`else
    assign dout = sub;
`endif

endmodule

// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
// Sequential AES-128 key schedule: emits round keys 0..10 one per handshake.
//   clk   : in  core clock, rising edge
//   reset : in  synchronous, active-high
//   bus   : aes_key_expand_if.slave
//           start/key in  : begin a schedule (accepted only when idle)
//           next      in  : consume round_key when key_valid is high
//           round_key/round_idx/key_valid/busy/done out
// Build option: AES_KEYEXP_SYNC_SBOX_EN registers the S-box and adds a
// one-cycle SUBST bubble after every handshake for rounds 0..9.
// -----------------------------------------------------------------------------
module aes_key_expand
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    aes_key_expand_if.slave  bus
);

    kexp_state_e  state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         key_valid, busy, done;

    word_t        sub_in, sub_rot;
    logic [3:0]   rc_idx;
    logic [127:0] expanded;

    assign sub_in = rot_word(key_q[31:0]);

    aes_subword u_subword (
`ifdef AES_KEYEXP_SYNC_SBOX_EN
        .clk  (clk),
`endif
        .din  (sub_in),
        .dout (sub_rot)
    );

    // Clamp keeps the RCON index in range when idx_q is 10 (expanded unused then).
    assign rc_idx   = (idx_q < 4'd10) ? idx_q + 4'd1 : 4'd10;
    assign expanded = next_round_key(key_q, sub_rot, RCON[rc_idx]);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        idx_d     = idx_q;
        key_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    key_d   = bus.key;
                    idx_d   = 4'd0;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                key_valid = 1'b1;
                busy      = 1'b1;
                if (bus.next) begin
                    if (idx_q == 4'd10) begin
                        state_d = ST_FINISH;
                    end else begin
`ifdef AES_KEYEXP_SYNC_SBOX_EN
                        // S-box output for the current key lands next cycle.
                        state_d = ST_SUBST;
`else
                        key_d   = expanded;
                        idx_d   = idx_q + 4'd1;
`endif
                    end
                end
            end
`ifdef AES_KEYEXP_SYNC_SBOX_EN
            ST_SUBST: begin
                busy    = 1'b1;
                key_d   = expanded;
                idx_d   = idx_q + 4'd1;
                state_d = ST_PRESENT;
            end
`endif
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.round_key = key_q;
    assign bus.round_idx = idx_q;
    assign bus.key_valid = key_valid;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule
